// File: rtl/mips_exec_pkg.sv
// Shared constants for the MIPS execute stage: ALU select codes, main-control
// ALU operation classes and the funct/opcode values the decoder recognises.
package mips_exec_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned FUNCT_W    = 4;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned ALU_SEL_W  = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_e;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b0010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 4'b0111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 4'b1010;

  localparam logic [OPCODE_W-1:0] OPC_ORI = 6'b001101;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps main-control aluop plus funct/opcode to an ALU select.
module alu_ctrl_dec
  import mips_exec_pkg::*;
(
  input  logic [ALUOP_W-1:0]   aluop,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [OPCODE_W-1:0]  opcode,
  output logic [ALU_SEL_W-1:0] alu_sel
);

  always_comb begin
    alu_sel = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_sel = ALU_ADD;
      ALUOP_SUB: alu_sel = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_sel = ALU_ADD;
          FUNCT_SUB: alu_sel = ALU_SUB;
          FUNCT_AND: alu_sel = ALU_AND;
          FUNCT_OR:  alu_sel = ALU_OR;
          FUNCT_NOR: alu_sel = ALU_NOR;
          FUNCT_SLT: alu_sel = ALU_SLT;
          default:   alu_sel = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: alu_sel = (opcode == OPC_ORI) ? ALU_OR : ALU_ADD;
      default:     alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS execute stage: ALU datapath with combinational flags, PC adders and a
// registered status-flag triple captured under flag_en.
module mips_exec_unit
  import mips_exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ALUOP_W-1:0]   aluop,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      sext_imm,
  input  logic                 flag_en,
  output logic [XLEN-1:0]      result,
  output logic                 zero,
  output logic                 ovf,
  output logic                 neg,
  output logic [XLEN-1:0]      pc_plus4,
  output logic [XLEN-1:0]      br_target,
  output logic                 v_flag,
  output logic                 z_flag,
  output logic                 n_flag,
  output logic [ALU_SEL_W-1:0] alu_sel
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            slt;

  alu_ctrl_dec u_dec (
    .aluop   (aluop),
    .funct   (funct),
    .opcode  (opcode),
    .alu_sel (alu_sel)
  );

  assign sum  = a + b;
  assign diff = a - b;
  // Direct signed compare stays correct when a-b would overflow.
  assign slt  = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_sel)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: begin
        result = sum;
        ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_SLT: result = {(XLEN-1)'(0), slt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[XLEN-1];

  // Branch offset is word-scaled; the top two immediate bits fall off the shift.
  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc_plus4 + (sext_imm << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (flag_en) begin
      v_flag <= ovf;
      z_flag <= zero;
      n_flag <= neg;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed literal cases plus
// randomized operands checked every cycle against an arithmetic model.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  aluop = '0;
  logic [3:0]  funct = '0;
  logic [5:0]  opcode = '0;
  logic [31:0] a = '0, b = '0, pc = '0, sext_imm = '0;
  logic        flag_en = 1'b0;
  logic [31:0] result, pc_plus4, br_target;
  logic        zero, ovf, neg, v_flag, z_flag, n_flag;
  logic [2:0]  alu_sel;

  int n_cmp = 0;
  int n_err = 0;
  logic check_en = 1'b0;
  logic [2:0] m_flags = '0;

  mips_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .opcode(opcode),
    .a(a), .b(b), .pc(pc), .sext_imm(sext_imm), .flag_en(flag_en),
    .result(result), .zero(zero), .ovf(ovf), .neg(neg),
    .pc_plus4(pc_plus4), .br_target(br_target),
    .v_flag(v_flag), .z_flag(z_flag), .n_flag(n_flag), .alu_sel(alu_sel)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] m_sel(logic [1:0] op, logic [3:0] fn, logic [5:0] opc);
    if (op == 2'd0) return 3'b010;
    if (op == 2'd1) return 3'b110;
    if (op == 2'd3) return (opc == 6'd13) ? 3'b001 : 3'b010;
    if (fn == 4'd0)  return 3'b010;
    if (fn == 4'd2)  return 3'b110;
    if (fn == 4'd4)  return 3'b000;
    if (fn == 4'd5)  return 3'b001;
    if (fn == 4'd7)  return 3'b100;
    if (fn == 4'd10) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [31:0] m_res(logic [2:0] s, logic [31:0] x, logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (s)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b100: return ~(x | y);
      3'b010: return 32'((sx + sy) & 64'hFFFF_FFFF);
      3'b110: return 32'((sx - sy) & 64'hFFFF_FFFF);
      3'b111: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Overflow: the exact signed result does not fit in 32 bits.
  function automatic logic m_ovf(logic [2:0] s, logic [31:0] x, logic [31:0] y);
    longint r;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    if (s == 3'b010)      r = sx + sy;
    else if (s == 3'b110) r = sx - sy;
    else                  return 1'b0;
    return (r >= 64'sh8000_0000) || (r < -64'sh8000_0000);
  endfunction

  function automatic logic [2:0] m_vzn();
    logic [2:0]  s = m_sel(aluop, funct, opcode);
    logic [31:0] r = m_res(s, a, b);
    return {m_ovf(s, a, b), (r == 32'd0), r[31]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       m_flags <= 3'b000;
    else if (flag_en) m_flags <= m_vzn();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [2:0]  s;
      logic [31:0] r;
      s = m_sel(aluop, funct, opcode);
      r = m_res(s, a, b);
      chk("alu_sel", 32'(alu_sel), 32'(s));
      chk("result", result, r);
      chk("zero", 32'(zero), 32'(r == 32'd0));
      chk("neg", 32'(neg), 32'(r[31]));
      chk("ovf", 32'(ovf), 32'(m_ovf(s, a, b)));
      chk("pc_plus4", pc_plus4, 32'((longint'(pc) + 4) & 64'hFFFF_FFFF));
      chk("br_target", br_target,
          32'((longint'(pc) + 4 + longint'($signed(sext_imm)) * 4) & 64'hFFFF_FFFF));
      chk("vzn_flags", 32'({v_flag, z_flag, n_flag}), 32'(m_flags));
    end
  end

  task automatic set_alu(input logic [1:0] op, input logic [3:0] fn, input logic [5:0] opc,
                         input logic [31:0] x, input logic [31:0] y);
    aluop = op; funct = fn; opcode = opc; a = x; b = y;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #3;
    chk("reset_flags", 32'({v_flag, z_flag, n_flag}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Signed add overflow into the sign bit
    @(posedge clk); #1;
    set_alu(2'b10, 4'b0000, 6'd0, 32'h7FFF_FFFF, 32'h1);
    flag_en = 1'b1;
    #1;
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_flags", 32'({ovf, neg, zero}), 32'b110);
    chk("add_sel", 32'(alu_sel), 32'b010);
    @(posedge clk); #1;
    chk("add_ovf_vn", 32'({v_flag, z_flag, n_flag}), 32'b101);

    // Flags hold with flag_en low; SUB to zero
    flag_en = 1'b0;
    set_alu(2'b01, 4'd0, 6'd0, 32'd5, 32'd5);
    #1;
    chk("sub_zero_result", result, 32'd0);
    chk("sub_zero_flags", 32'({zero, ovf}), 32'b10);
    @(posedge clk); #1;
    chk("hold_flags", 32'({v_flag, z_flag, n_flag}), 32'b101);
    rst_n = 1'b0;
    #1;
    chk("async_clear", 32'({v_flag, z_flag, n_flag}), 32'd0);
    flag_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_ignores_en", 32'({v_flag, z_flag, n_flag}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_capture", 32'({v_flag, z_flag, n_flag}), 32'b010);
    flag_en = 1'b0;

    // SLT across the overflow boundary
    set_alu(2'b10, 4'b1010, 6'd0, 32'h8000_0000, 32'h1);
    #1;
    chk("slt_min", result, 32'd1);
    set_alu(2'b10, 4'b1010, 6'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    #1;
    chk("slt_max", result, 32'd0);

    set_alu(2'b11, 4'd0, 6'b001101, 32'h0000_F000, 32'h0000_00FF);
    #1;
    chk("ori_result", result, 32'h0000_F0FF);
    chk("ori_sel", 32'(alu_sel), 32'b001);
    set_alu(2'b10, 4'b0111, 6'd0, 32'd0, 32'd0);
    #1;
    chk("nor_result", result, 32'hFFFF_FFFF);
    set_alu(2'b10, 4'b0110, 6'd0, 32'd3, 32'd4);
    #1;
    chk("undef_funct_add", result, 32'd7);

    pc = 32'h0000_0010; sext_imm = 32'hFFFF_FFFE;
    #1;
    chk("pc_plus4", pc_plus4, 32'h0000_0014);
    chk("br_target_back", br_target, 32'h0000_000C);
    pc = 32'hFFFF_FFFC; sext_imm = 32'hC000_0001;
    #1;
    chk("pc_wrap", pc_plus4, 32'd0);
    chk("br_drop_hi", br_target, 32'd4);

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      aluop    = 2'($urandom_range(0, 3));
      funct    = ($urandom_range(0, 1) == 0) ? 4'($urandom()) : 4'b1010;
      opcode   = ($urandom_range(0, 1) == 0) ? 6'b001101 : 6'($urandom());
      a        = pick();
      b        = pick();
      pc       = pick();
      sext_imm = pick();
      flag_en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 Ports SHALL be one per line as name direction width meaning, clock and reset first:
REQ-002 clk  input  1  single clock; rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 aluop  input  2  main-control ALU operation class.
REQ-005 funct  input  4  instruction bits [3:0].
REQ-006 opcode  input  6  instruction bits [31:26].
REQ-007 a  input  32  operand A (rs data).
REQ-008 b  input  32  operand B (rt data or extended immediate).
REQ-009 pc  input  32  current program counter.
REQ-010 sext_imm  input  32  sign-extended 16-bit immediate.
REQ-011 flag_en  input  1  status-register capture enable.
REQ-012 result  output  32  ALU result, combinational.
REQ-013 zero, ovf, neg  output  1 each  combinational ALU flags.
REQ-014 pc_plus4  output  32  pc + 4, combinational.
REQ-015 br_target  output  32  pc_plus4 + (sext_imm << 2), combinational.
REQ-016 v_flag, z_flag, n_flag  output  1 each  registered status flags.
REQ-017 alu_sel  output  3  decoded ALU operation, for observability.
REQ-018 No parameters; all widths fixed.

Function
REQ-019 alu_sel encodings SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
REQ-020 Decode: aluop 00 -> ADD; aluop 01 -> SUB.
REQ-021 Decode aluop 10 by funct: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0111 NOR, 1010 SLT; any other funct -> ADD.
REQ-022 Decode aluop 11 by opcode: 001101 (ori) -> OR; any other opcode -> ADD.
REQ-023 ADD/SUB SHALL be 32-bit modulo two's complement; carry out discarded.
REQ-024 SLT SHALL be a true signed compare: result = 1 if $signed(a) < $signed(b), else 0; it SHALL be correct even when a-b overflows.
REQ-025 Undefined alu_sel codes (011, 101) SHALL give result 0.
REQ-026 zero = (result == 0); neg = result[31].
REQ-027 ovf SHALL be 1 only for ADD when a[31]==b[31] and result[31]!=a[31], and for SUB when a[31]!=b[31] and result[31]!=a[31]; 0 for all other operations.
REQ-028 All outputs except v/z/n_flag SHALL be purely combinational, zero latency.
REQ-029 pc_plus4 and br_target SHALL wrap modulo 2^32; the shift SHALL drop sext_imm[31:30].
REQ-030 On a rising clk with flag_en=1, v_flag/z_flag/n_flag SHALL load ovf/zero/neg; with flag_en=0 they SHALL hold.
REQ-031 Registered flags SHALL reflect the value one cycle later; combinational flags SHALL not depend on them.

Reset
REQ-032 rst_n=0 SHALL immediately clear v_flag, z_flag and n_flag to 0, regardless of clk.
REQ-033 While rst_n=0, flag_en SHALL be ignored; the first capture SHALL be the first rising clk after rst_n deasserts.
REQ-034 Reset SHALL not affect the combinational outputs.

Structure
REQ-035 The alu_sel encodings and the ori opcode constant SHALL live in a shared package (mips_exec_pkg).
REQ-036 The aluop/funct/opcode decoder SHALL be one sub-module, alu_ctrl_dec; the datapath, adders and flag register SHALL stay in the top module.

Verification
REQ-037 aluop=10, funct=0000, a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, neg=1, zero=0; after clk with flag_en=1, v_flag=1, n_flag=1.
REQ-038 aluop=01, a=5, b=5 -> result 0, zero=1, ovf=0; aluop=10, funct=1010, a=0x80000000, b=1 -> result 1.
REQ-039 aluop=11, opcode=001101, a=0x0000F000, b=0x000000FF -> result 0x0000F0FF, alu_sel=001; funct=0111, aluop=10, a=0, b=0 -> result 0xFFFFFFFF.
REQ-040 pc=0x00000010, sext_imm=0xFFFFFFFE -> pc_plus4=0x00000014, br_target=0x0000000C; pc=0xFFFFFFFC -> pc_plus4=0.
REQ-041 Capture flags with v=1, then set flag_en=0 and change operands -> flags hold; assert rst_n=0 between clock edges -> all flags 0 immediately.
